// File: rtl/move_walker_pkg.sv
// Shared types and bounds for the move-list walker.
// Board constants mirror the vchess.vh values so the walker builds standalone.
package move_walker_pkg;

    localparam int PIECE_BITS        = 4;
    localparam int MAX_POSITIONS_DEF = 256;
    localparam logic [PIECE_BITS-1:0] EMPTY_POSN = '0;

    localparam int READ_LATENCY_MAX = 7;
    localparam int CLEAR_WAIT_MIN   = 1;
    localparam int CLEAR_WAIT_MAX   = 15;
    localparam int WAIT_W           = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_CLEAR,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/move_walker.sv
// Walks the all_moves RAM one index at a time and streams each move out on a
// valid/ready handshake, with emit limit, abort and a clear/hold tail.
module move_walker
    import move_walker_pkg::*;
#(
    parameter int PIECE_WIDTH        = PIECE_BITS,
    parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
    parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
    parameter int MAX_POSITIONS      = MAX_POSITIONS_DEF,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
    parameter int READ_LATENCY       = 1,
    parameter int CLEAR_WAIT         = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
    output logic [MAX_POSITIONS_LOG2-1:0] move_index,
    output logic                          clear_moves,
    input  logic [BOARD_WIDTH-1:0]        board_in,
    input  logic                          white_to_move_in,
    input  logic [3:0]                    castle_mask_in,
    input  logic [3:0]                    en_passant_col_in,
    input  logic [MAX_POSITIONS_LOG2:0]   max_emit,
    input  logic                          abort,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BOARD_WIDTH-1:0]        board_out,
    output logic                          white_to_move_out,
    output logic [3:0]                    castle_mask_out,
    output logic [3:0]                    en_passant_col_out,
    output logic [MAX_POSITIONS_LOG2-1:0] out_index,
    output logic                          out_last,
    output logic [MAX_POSITIONS_LOG2:0]   emitted,
    output logic                          busy,
    output logic                          done
);

    localparam int IW = MAX_POSITIONS_LOG2;
    localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD = {64{EMPTY_POSN}};
    localparam logic [WAIT_W-1:0]      RL_LOAD     = WAIT_W'(READ_LATENCY);
    localparam logic [WAIT_W-1:0]      CW_LOAD     = WAIT_W'(CLEAR_WAIT - 1);
    localparam logic [IW:0]            ONE_W       = 1;
    localparam logic [IW-1:0]          ONE_I       = 1;

    state_e                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [IW-1:0]           cnt_q, cnt_d;
    logic [IW:0]             lim_q, lim_d;
    logic [IW:0]             emitted_q, emitted_d;
    logic [IW-1:0]           move_index_q, move_index_d;
    logic [IW-1:0]           out_index_q, out_index_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [BOARD_WIDTH-1:0]  board_q, board_d;
    logic                    wtm_q, wtm_d;
    logic [3:0]              castle_q, castle_d;
    logic [3:0]              ep_q, ep_d;

    // Widened by one bit so a count of MAX_POSITIONS-1 never wraps.
    logic [IW:0] idx_p1, emit_p1;
    assign idx_p1  = {1'b0, move_index_q} + ONE_W;
    assign emit_p1 = emitted_q + ONE_W;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        cnt_d        = cnt_q;
        lim_d        = lim_q;
        emitted_d    = emitted_q;
        move_index_d = move_index_q;
        out_index_d  = out_index_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        board_d      = board_q;
        wtm_d        = wtm_q;
        castle_d     = castle_q;
        ep_d         = ep_q;
        clear_moves  = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                move_index_d = '0;
                if (moves_ready) begin
                    cnt_d     = move_count;
                    lim_d     = max_emit;
                    emitted_d = '0;
                    if (move_count == '0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        wait_d  = RL_LOAD;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    board_d     = board_in;
                    wtm_d       = white_to_move_in;
                    castle_d    = castle_mask_in;
                    ep_d        = en_passant_col_in;
                    out_index_d = move_index_q;
                    out_last_d  = (idx_p1 >= {1'b0, cnt_q}) ||
                                  ((lim_q != '0) && (emit_p1 >= lim_q));
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // An accept on the abort edge still counts.
                if (out_valid_q && out_ready) begin
                    emitted_d   = emit_p1;
                    out_valid_d = 1'b0;
                    if (out_last_q || abort) begin
                        state_d = ST_CLEAR;
                    end else begin
                        move_index_d = move_index_q + ONE_I;
                        wait_d       = RL_LOAD;
                        state_d      = ST_FETCH;
                    end
                end else if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_moves  = 1'b1;
                move_index_d = '0;
                wait_d       = CW_LOAD;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            cnt_q        <= '0;
            lim_q        <= '0;
            emitted_q    <= '0;
            move_index_q <= '0;
            out_index_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            board_q      <= EMPTY_BOARD;
            wtm_q        <= 1'b0;
            castle_q     <= '0;
            ep_q         <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            cnt_q        <= cnt_d;
            lim_q        <= lim_d;
            emitted_q    <= emitted_d;
            move_index_q <= move_index_d;
            out_index_q  <= out_index_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            board_q      <= board_d;
            wtm_q        <= wtm_d;
            castle_q     <= castle_d;
            ep_q         <= ep_d;
        end
    end

    assign move_index         = move_index_q;
    assign out_valid          = out_valid_q;
    assign out_last           = out_last_q;
    assign out_index          = out_index_q;
    assign board_out          = board_q;
    assign white_to_move_out  = wtm_q;
    assign castle_mask_out    = castle_q;
    assign en_passant_col_out = ep_q;
    assign emitted            = emitted_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_move_walker.sv
// Randomised scoreboard bench for move_walker: a latency-accurate RAM model
// feeds the walker, a monitor checks every accepted beat and the tail timing.
module tb_move_walker;

    localparam int PW = 4;
    localparam int BW = PW * 64;
    localparam int MP = 32;
    localparam int IW = $clog2(MP);
    localparam int RL = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          moves_ready = 1'b0;
    logic [IW-1:0] move_count = '0;
    logic [IW:0]   max_emit = '0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] move_index;
    logic          clear_moves;
    logic [BW-1:0] board_in;
    logic          white_to_move_in;
    logic [3:0]    castle_mask_in, en_passant_col_in;
    logic          out_valid;
    logic [BW-1:0] board_out;
    logic          white_to_move_out;
    logic [3:0]    castle_mask_out, en_passant_col_out;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic [IW:0]   emitted;
    logic          busy, done;

    always #5 clk = ~clk;

    move_walker #(
        .PIECE_WIDTH(PW), .SIDE_WIDTH(PW * 8), .BOARD_WIDTH(BW),
        .MAX_POSITIONS(MP), .MAX_POSITIONS_LOG2(IW),
        .READ_LATENCY(RL), .CLEAR_WAIT(CW)
    ) dut (
        .clk(clk), .reset(reset), .moves_ready(moves_ready),
        .move_count(move_count), .move_index(move_index),
        .clear_moves(clear_moves), .board_in(board_in),
        .white_to_move_in(white_to_move_in), .castle_mask_in(castle_mask_in),
        .en_passant_col_in(en_passant_col_in), .max_emit(max_emit),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .board_out(board_out), .white_to_move_out(white_to_move_out),
        .castle_mask_out(castle_mask_out), .en_passant_col_out(en_passant_col_out),
        .out_index(out_index), .out_last(out_last), .emitted(emitted),
        .busy(busy), .done(done)
    );

    // Move RAM: data for an address appears RL cycles after the address changes.
    logic [BW-1:0] ram_b [MP];
    logic          ram_w [MP];
    logic [3:0]    ram_c [MP];
    logic [3:0]    ram_e [MP];
    logic [IW-1:0] apipe [RL];

    always @(posedge clk) begin
        apipe[0] <= move_index;
        for (int k = 1; k < RL; k++) apipe[k] <= apipe[k-1];
    end
    assign board_in          = ram_b[apipe[RL-1]];
    assign white_to_move_in  = ram_w[apipe[RL-1]];
    assign castle_mask_in    = ram_c[apipe[RL-1]];
    assign en_passant_col_in = ram_e[apipe[RL-1]];

    typedef struct {
        logic [IW-1:0] idx;
        logic [BW-1:0] board;
        logic          wtm;
        logic [3:0]    cm;
        logic [3:0]    ep;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int exp_first = 0, exp_clear_cyc = -1, clear_cyc = 0, prev_rise = 0;
    bit first_pend = 0, chk_gap = 0, have_rise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready pattern, changed a little after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !(out_valid && out_index == IW'(7));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks tail timing.
    bit            prev_v = 0, prev_stall = 0, prev_clear = 0;
    logic [BW+IW+10-1:0] saved;
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prev_v = 0; prev_stall = 0; prev_clear = 0; have_rise = 0;
        end else begin
            if (out_valid && !prev_v) begin
                if (first_pend) begin
                    chk("first_valid_cycle", cyc, exp_first);
                    first_pend = 0;
                end else if (chk_gap && have_rise) begin
                    chk("beat_spacing", cyc - prev_rise, RL + 2);
                end
                prev_rise = cyc;
                have_rise = 1;
            end
            if (out_valid && prev_stall)
                chk("stable_while_stalled",
                    {out_index, board_out, white_to_move_out, castle_mask_out, en_passant_col_out, out_last},
                    saved);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_index", out_index, '1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_index", out_index, e.idx);
                    chk("beat_board", board_out, e.board);
                    chk("beat_meta", {white_to_move_out, castle_mask_out, en_passant_col_out},
                        {e.wtm, e.cm, e.ep});
                    chk("beat_last", out_last, e.last);
                end
                if (out_last) exp_clear_cyc = cyc + 1;
            end
            prev_stall = out_valid && !out_ready;
            saved = {out_index, board_out, white_to_move_out, castle_mask_out, en_passant_col_out, out_last};
            if (clear_moves) begin
                chk("clear_cycle", cyc, exp_clear_cyc);
                chk("clear_single_pulse", prev_clear, 0);
                clear_cyc = cyc;
            end
            prev_clear = clear_moves;
            if (done) chk("done_after_clear", cyc - clear_cyc, CW);
            prev_v = out_valid;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_ctl"}, {clear_moves, done, busy}, 0);
        chk({tag, "_idx"}, {move_index, out_index}, 0);
        chk({tag, "_emitted"}, emitted, 0);
        chk({tag, "_data"}, {board_out, white_to_move_out, castle_mask_out, en_passant_col_out}, 0);
    endtask

    task automatic wait_for(input string name, input int which, input int budget);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (b < budget && !(which == 0 ? done :
                                   which == 1 ? out_valid :
                                   (out_valid && out_index == IW'(7))));
        chk(name, b < budget, 1);
    endtask

    // One walk: mode 0 full ready, 1 random ready, 2 abort on stall of index 7,
    // 3 reset while presenting.
    task automatic walk(input int cnt, input int lim, input int mode, input bit abort_at_start);
        int n, n_push;
        beat_t e;
        for (int i = 0; i < MP; i++) begin
            for (int w = 0; w < BW / 32; w++) ram_b[i][w*32 +: 32] = $urandom;
            ram_w[i] = 1'($urandom);
            ram_c[i] = 4'($urandom);
            ram_e[i] = 4'($urandom);
        end
        n = (lim != 0 && lim < cnt) ? lim : cnt;
        n_push = (mode == 2) ? 7 : (mode == 3) ? 0 : n;
        for (int k = 0; k < n_push; k++) begin
            e.idx = IW'(k); e.board = ram_b[k]; e.wtm = ram_w[k];
            e.cm = ram_c[k]; e.ep = ram_e[k]; e.last = (k == n - 1);
            exp_q.push_back(e);
        end
        rdy_mode = mode;
        chk_gap = (mode == 0);
        @(posedge clk);
        #1;
        move_count = IW'(cnt);
        max_emit = (IW+1)'(lim);
        moves_ready = 1'b1;
        abort = abort_at_start;
        have_rise = 0;
        first_pend = (cnt != 0);
        exp_first = cyc + 2 + RL;
        if (cnt == 0) exp_clear_cyc = cyc + 1;
        @(posedge clk);
        #1;
        moves_ready = 1'b0;
        abort = 1'b0;
        move_count = IW'($urandom);
        max_emit = (IW+1)'($urandom);
        if (mode == 2) begin
            wait_for("reach_index7", 2, 500);
            repeat (2) @(posedge clk);
            #1;
            abort = 1'b1;
            exp_clear_cyc = cyc + 1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            chk("abort_drops_valid", out_valid, 0);
            chk("abort_clear_now", clear_moves, 1);
        end
        if (mode == 3) begin
            wait_for("reach_present", 1, 500);
            @(posedge clk);
            #1;
            reset = 1'b1;
            exp_clear_cyc = -1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            chk_reset_state("midwalk_reset");
            repeat (CW + 4) @(posedge clk);
            #1;
            chk("reset_stays_idle", busy, 0);
            return;
        end
        wait_for("done_reached", 0, 4000);
        chk("emitted_final", emitted, (mode == 2) ? 7 : n);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b0;
        walk(26, 0, 0, 0);
        walk(0, 0, 0, 0);
        chk("empty_walk_emitted", emitted, 0);
        walk(26, 0, 1, 0);
        walk(26, 5, 0, 0);
        walk(31, 0, 1, 0);
        walk(10, 10, 1, 0);
        walk(10, 11, 0, 0);
        walk(1, 0, 0, 0);
        walk(20, 0, 2, 0);
        @(posedge clk);
        #1;
        exp_clear_cyc = -1;
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort_ignored", busy, 0);
        walk(12, 0, 0, 1);
        walk(20, 0, 3, 0);
        walk(5, 0, 1, 0);
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
